// File: rtl/reg_bus_sequencer.sv
// reg_bus_sequencer
//   Micro-op sequencer and the only arbiter of the shared 4-bit register-file
//   BUS. It accepts one micro-op at a time over a valid/ready handshake and
//   drives the regA/regB select strobes and the external-agent grant. There is
//   never more than one BUS driver in a cycle. Idle turnaround cycles are
//   inserted after every op that uses the BUS.
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-high reset
//   op_valid  in   micro-op request valid
//   op[2:0]   in   micro-op code
//   op_ready  out  op can be accepted (IDLE only)
//   done      out  one-cycle pulse when the op completes
//   err       out  one-cycle pulse with done when an ext op timed out
//   rs1/rs2   out  regA load from immediate / from BUS
//   ws1       out  regA drives BUS
//   rs3/rs4   out  regB load from immediate / from BUS
//   ws2       out  regB drives BUS
//   ext_gnt   out  external agent may drive BUS
//   ext_ack   in   external agent has valid data on BUS
//   out_stb   out  external agent samples BUS now
module reg_bus_sequencer #(
    parameter int TURN_CYCLES = 1,
    parameter int EXT_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       op_valid,
    input  logic [2:0] op,
    output logic       op_ready,
    output logic       done,
    output logic       err,
    output logic       rs1,
    output logic       rs2,
    output logic       ws1,
    output logic       rs3,
    output logic       rs4,
    output logic       ws2,
    output logic       ext_gnt,
    input  logic       ext_ack,
    output logic       out_stb
);

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_LDA_IMM = 3'd1;
    localparam logic [2:0] OP_LDB_IMM = 3'd2;
    localparam logic [2:0] OP_MOV_AB  = 3'd3;
    localparam logic [2:0] OP_MOV_BA  = 3'd4;
    localparam logic [2:0] OP_LDA_EXT = 3'd5;
    localparam logic [2:0] OP_LDB_EXT = 3'd6;
    localparam logic [2:0] OP_OUT_A   = 3'd7;

    localparam logic [3:0] WAIT_LAST = 4'(EXT_TIMEOUT - 1);
    localparam logic [1:0] TURN_LAST = 2'(TURN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, LATCH, TURN} state_t;

    typedef struct packed {
        logic op_ready;
        logic done;
        logic err;
        logic rs1;
        logic rs2;
        logic ws1;
        logic rs3;
        logic rs4;
        logic ws2;
        logic ext_gnt;
        logic out_stb;
    } outs_t;

    state_t     state, state_n;
    logic [2:0] op_q, op_n;
    logic [3:0] wait_cnt, wait_n;
    logic [1:0] turn_cnt, turn_n;
    logic       abort_q, abort_n;
    outs_t      outs;

    function automatic logic is_ext(input logic [2:0] o);
        return (o == OP_LDA_EXT) || (o == OP_LDB_EXT);
    endfunction

    // NOP and the immediate loads never touch the BUS
    function automatic logic is_short(input logic [2:0] o);
        return (o == OP_NOP) || (o == OP_LDA_IMM) || (o == OP_LDB_IMM);
    endfunction

    // Outputs as a pure function of (state, held op, turn count, abort flag).
    // The driver enable stays on through LATCH so the BUS is stable at the
    // load edge.
    function automatic outs_t decode(input state_t st, input logic [2:0] o,
                                     input logic [1:0] tc, input logic ab);
        outs_t r;
        r = '0;
        case (st)
            IDLE: r.op_ready = 1'b1;
            DRIVE: begin
                r.ws1     = (o == OP_MOV_BA) || (o == OP_OUT_A);
                r.ws2     = (o == OP_MOV_AB);
                r.ext_gnt = is_ext(o);
            end
            LATCH: begin
                r.ws1     = (o == OP_MOV_BA) || (o == OP_OUT_A);
                r.ws2     = (o == OP_MOV_AB);
                r.ext_gnt = is_ext(o);
                r.rs1     = (o == OP_LDA_IMM);
                r.rs3     = (o == OP_LDB_IMM);
                r.rs2     = (o == OP_MOV_AB) || (o == OP_LDA_EXT);
                r.rs4     = (o == OP_MOV_BA) || (o == OP_LDB_EXT);
                r.out_stb = (o == OP_OUT_A);
                r.done    = is_short(o);
            end
            TURN: begin
                r.done = (tc == TURN_LAST);
                r.err  = (tc == TURN_LAST) && ab;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state;
        op_n    = op_q;
        wait_n  = wait_cnt;
        turn_n  = turn_cnt;
        abort_n = abort_q;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    op_n    = op;
                    wait_n  = 4'd0;
                    turn_n  = 2'd0;
                    abort_n = 1'b0;
                    state_n = is_short(op) ? LATCH : DRIVE;
                end
            end
            DRIVE: begin
                if (!is_ext(op_q)) begin
                    state_n = LATCH;
                end else if (ext_ack) begin
                    state_n = LATCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    // agent never answered: release the BUS without loading
                    state_n = TURN;
                    turn_n  = 2'd0;
                    abort_n = 1'b1;
                end else begin
                    wait_n = wait_cnt + 4'd1;
                end
            end
            LATCH: begin
                if (is_short(op_q)) begin
                    state_n = IDLE;
                end else begin
                    state_n = TURN;
                    turn_n  = 2'd0;
                end
            end
            TURN: begin
                if (turn_cnt == TURN_LAST) begin
                    state_n = IDLE;
                    turn_n  = 2'd0;
                end else begin
                    turn_n = turn_cnt + 2'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 3'd0;
            wait_cnt <= 4'd0;
            turn_cnt <= 2'd0;
            abort_q  <= 1'b0;
            outs     <= decode(IDLE, 3'd0, 2'd0, 1'b0);
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            wait_cnt <= wait_n;
            turn_cnt <= turn_n;
            abort_q  <= abort_n;
            outs     <= decode(state_n, op_n, turn_n, abort_n);
        end
    end

    assign op_ready = outs.op_ready;
    assign done     = outs.done;
    assign err      = outs.err;
    assign rs1      = outs.rs1;
    assign rs2      = outs.rs2;
    assign ws1      = outs.ws1;
    assign rs3      = outs.rs3;
    assign rs4      = outs.rs4;
    assign ws2      = outs.ws2;
    assign ext_gnt  = outs.ext_gnt;
    assign out_stb  = outs.out_stb;

endmodule

// File: tb/tb_reg_bus_sequencer.sv
// tb_reg_bus_sequencer
//   Bench for reg_bus_sequencer: regA, regB, the shared BUS and an external
//   agent around the sequencer, with a reference model of register contents,
//   strobe counts and completion timing.
`timescale 1ns/1ps
module tb_reg_bus_sequencer;

    localparam int TC = 1;
    localparam int TO = 8;

    localparam logic [2:0] NOP     = 3'd0;
    localparam logic [2:0] LDA_IMM = 3'd1;
    localparam logic [2:0] LDB_IMM = 3'd2;
    localparam logic [2:0] MOV_AB  = 3'd3;
    localparam logic [2:0] MOV_BA  = 3'd4;
    localparam logic [2:0] LDA_EXT = 3'd5;
    localparam logic [2:0] LDB_EXT = 3'd6;
    localparam logic [2:0] OUT_A   = 3'd7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       op_valid = 1'b0;
    logic [2:0] op = 3'd0;
    logic       ext_ack = 1'b0;
    logic       op_ready, done, err, rs1, rs2, ws1, rs3, rs4, ws2, ext_gnt, out_stb;

    logic [3:0] imm = 4'd0;
    logic [3:0] ext_val = 4'd0;
    logic [3:0] rega, regb, out_cap, bus;

    logic [3:0] model_a, model_b, model_out;
    bit         a_known = 0, b_known = 0;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_bus_sequencer #(.TURN_CYCLES(TC), .EXT_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .op_ready(op_ready),
        .done(done), .err(err), .rs1(rs1), .rs2(rs2), .ws1(ws1), .rs3(rs3),
        .rs4(rs4), .ws2(ws2), .ext_gnt(ext_gnt), .ext_ack(ext_ack), .out_stb(out_stb)
    );

    // BUS carries the value of whichever agent holds the drive enable;
    // contention is flagged by the per-cycle monitor below
    always_comb begin
        bus = 4'h0;
        if (ws1)          bus = rega;
        else if (ws2)     bus = regb;
        else if (ext_gnt) bus = ext_val;
    end

    always @(posedge clk) begin
        if (rs1)      rega <= imm;
        else if (rs2) rega <= bus;
        if (rs3)      regb <= imm;
        else if (rs4) regb <= bus;
        if (out_stb)  out_cap <= bus;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // per-cycle invariants
    always @(negedge clk) begin
        if (!rst) begin
            check("drv_onehot", 32'($onehot0({ws1, ws2, ext_gnt})), 32'd1);
            check("ld_onehot", 32'($onehot0({rs1, rs2, rs3, rs4})), 32'd1);
            check("ld_own_drv", 32'((ws1 && (rs1 || rs2)) || (ws2 && (rs3 || rs4))), 32'd0);
            check("idle_quiet", 32'(op_ready && (ws1 || ws2 || ext_gnt)), 32'd0);
            check("err_wo_done", 32'(err && !done), 32'd0);
        end
    end

    // Issue one op and compare the whole transaction with the model.
    // d = number of granted cycles the agent waits before acking (d >= TO: never).
    task automatic run_op(input logic [2:0] code, input logic [3:0] iv,
                          input logic [3:0] ev, input int d);
        int lat, e_ws1, e_ws2, e_gnt, n, c_ws1, c_ws2, c_gnt;
        logic exp_err;
        logic [19:0] exp_ld, ld_cnt;
        bit seen, is_ext_op;

        // reference: expected timing, strobe counts ({rs1,rs2,rs3,rs4,out_stb}
        // as nibbles) and register effects
        lat = 1; e_ws1 = 0; e_ws2 = 0; e_gnt = 0; exp_err = 1'b0; exp_ld = 20'h0;
        is_ext_op = (code == LDA_EXT) || (code == LDB_EXT);
        case (code)
            LDA_IMM: begin exp_ld = 20'h10000; model_a = iv; a_known = 1; end
            LDB_IMM: begin exp_ld = 20'h00100; model_b = iv; b_known = 1; end
            MOV_AB:  begin lat = 2 + TC; e_ws2 = 2; exp_ld = 20'h01000; model_a = model_b; a_known = b_known; end
            MOV_BA:  begin lat = 2 + TC; e_ws1 = 2; exp_ld = 20'h00010; model_b = model_a; b_known = a_known; end
            OUT_A:   begin lat = 2 + TC; e_ws1 = 2; exp_ld = 20'h00001; model_out = model_a; end
            LDA_EXT, LDB_EXT: begin
                if (d < TO) begin
                    lat = d + 2 + TC;
                    e_gnt = d + 2;
                    if (code == LDA_EXT) begin exp_ld = 20'h01000; model_a = ev; a_known = 1; end
                    else                 begin exp_ld = 20'h00010; model_b = ev; b_known = 1; end
                end else begin
                    lat = TO + TC;
                    e_gnt = TO;
                    exp_err = 1'b1;
                end
            end
            default: ;
        endcase

        @(negedge clk);
        check("ready", 32'(op_ready), 32'd1);
        op_valid = 1'b1;
        op = code;
        imm = iv;
        ext_val = ev;
        ext_ack = 1'b0;
        @(posedge clk);
        #1;
        op = 3'($urandom);  // request stays valid while busy; must be ignored

        n = 0; seen = 0; c_ws1 = 0; c_ws2 = 0; c_gnt = 0; ld_cnt = 20'h0;
        while (!seen && n < 64) begin
            @(negedge clk);
            n++;
            if (ws1) c_ws1++;
            if (ws2) c_ws2++;
            if (ext_gnt) c_gnt++;
            ld_cnt = ld_cnt + {3'b0, rs1, 3'b0, rs2, 3'b0, rs3, 3'b0, rs4, 3'b0, out_stb};
            if (done) begin
                seen = 1;
                check("err", 32'(err), 32'(exp_err));
                op_valid = 1'b0;
            end
            if (is_ext_op) ext_ack = ext_gnt && (c_gnt > d);
            else           ext_ack = 1'($urandom);
        end
        ext_ack = 1'b0;
        op_valid = 1'b0;
        check("latency", 32'(n), 32'(lat));
        check("ws1_cycles", 32'(c_ws1), 32'(e_ws1));
        check("ws2_cycles", 32'(c_ws2), 32'(e_ws2));
        check("gnt_cycles", 32'(c_gnt), 32'(e_gnt));
        check("load_strobes", 32'(ld_cnt), 32'(exp_ld));

        @(posedge clk);
        #1;
        if (a_known) check("regA", 32'(rega), 32'(model_a));
        if (b_known) check("regB", 32'(regb), 32'(model_b));
        if (code == OUT_A) check("out_bus", 32'(out_cap), 32'(model_out));
    endtask

    initial begin
        int d;
        logic [2:0] c;

        // reset state
        repeat (3) @(negedge clk);
        check("reset_outs", 32'({op_ready, done, err, rs1, rs2, ws1, rs3, rs4, ws2, ext_gnt, out_stb}), 32'h400);
        rst = 1'b0;

        // immediate loads, then B->A move
        run_op(LDA_IMM, 4'h5, 4'h0, 0);
        run_op(LDB_IMM, 4'h9, 4'h0, 0);
        run_op(MOV_AB, 4'h0, 4'h0, 0);

        // reset in the middle of a MOV_AB
        @(negedge clk);
        op_valid = 1'b1;
        op = MOV_AB;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
        check("rst_pre_ws2", 32'(ws2), 32'd1);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("rst_outs", 32'({op_ready, done, err, rs1, rs2, ws1, rs3, rs4, ws2, ext_gnt, out_stb}), 32'h400);
        end
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_outs", 32'({op_ready, done, err, rs1, rs2, ws1, rs3, rs4, ws2, ext_gnt, out_stb}), 32'h400);
        end
        check("rst_regA", 32'(rega), 32'(model_a));

        // ext load acked on the third granted cycle, ext timeout, output
        run_op(LDA_EXT, 4'h0, 4'h6, 2);
        run_op(LDB_EXT, 4'h0, 4'h3, TO + 4);
        run_op(LDA_IMM, 4'h9, 4'h0, 0);
        run_op(OUT_A, 4'h0, 4'h0, 0);
        run_op(MOV_BA, 4'h0, 4'h0, 0);
        run_op(NOP, 4'hf, 4'h0, 0);
        run_op(LDB_EXT, 4'h0, 4'hc, TO - 1);
        run_op(LDA_EXT, 4'h0, 4'ha, 0);

        // random op stream
        for (int i = 0; i < 150; i++) begin
            c = 3'($urandom);
            d = int'($urandom_range(0, TO + 2));
            run_op(c, 4'($urandom), 4'($urandom), d);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
